// File: rtl/point_bbox_acc.sv
// Per-frame bounding box (per-component unsigned min/max) and saturating point count
// over a packed {x,y} point stream, with one valid/ready result per frame.
module point_bbox_acc #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_point,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_min,
  output logic [15:0]      out_max,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [15:0]      acc_min;
  logic [15:0]      acc_max;
  logic [CNT_W-1:0] acc_cnt;
  logic             acc_ovf;

  logic [15:0]      nxt_min;
  logic [15:0]      nxt_max;
  logic [CNT_W-1:0] nxt_cnt;
  logic             nxt_ovf;
  logic             accept;

  function automatic logic [15:0] box_min(input logic [15:0] a, input logic [15:0] b);
    logic [7:0] x;
    logic [7:0] y;
    x = (b[15:8] < a[15:8]) ? b[15:8] : a[15:8];
    y = (b[7:0]  < a[7:0])  ? b[7:0]  : a[7:0];
    return {x, y};
  endfunction

  function automatic logic [15:0] box_max(input logic [15:0] a, input logic [15:0] b);
    logic [7:0] x;
    logic [7:0] y;
    x = (b[15:8] > a[15:8]) ? b[15:8] : a[15:8];
    y = (b[7:0]  > a[7:0])  ? b[7:0]  : a[7:0];
    return {x, y};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? CNT_MAX : c + CNT_ONE;
  endfunction

  assign in_ready = (state != HOLD);
  assign accept   = in_valid && in_ready;

  // Candidate accumulator values; only committed on an accepted point, so
  // unqualified input data never reaches state.
  always_comb begin
    nxt_min = acc_min;
    nxt_max = acc_max;
    nxt_cnt = acc_cnt;
    nxt_ovf = acc_ovf;
    if (state == IDLE) begin
      nxt_min = in_point;
      nxt_max = in_point;
      nxt_cnt = CNT_ONE;
      nxt_ovf = 1'b0;
    end else begin
      nxt_min = box_min(acc_min, in_point);
      nxt_max = box_max(acc_max, in_point);
      nxt_cnt = sat_inc(acc_cnt);
      nxt_ovf = acc_ovf | (acc_cnt == CNT_MAX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc_min   <= 16'hFFFF;
      acc_max   <= 16'h0000;
      acc_cnt   <= '0;
      acc_ovf   <= 1'b0;
      out_valid <= 1'b0;
      out_min   <= 16'hFFFF;
      out_max   <= 16'h0000;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (accept) begin
            acc_min <= nxt_min;
            acc_max <= nxt_max;
            acc_cnt <= nxt_cnt;
            acc_ovf <= nxt_ovf;
            if (in_last) begin
              out_min   <= nxt_min;
              out_max   <= nxt_max;
              out_count <= nxt_cnt;
              out_ovf   <= nxt_ovf;
              out_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              state <= ACC;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_point_bbox_acc.sv
// Bench for point_bbox_acc: a wide-counter and a 2-bit-counter instance share stimulus;
// table vectors, hand sequences for stall/reset, and random frames against a reference model.
module tb_point_bbox_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;
  logic [15:0] in_point;

  logic        a_in_ready, a_out_valid, a_ovf;
  logic [15:0] a_min, a_max, a_cnt;
  logic        b_in_ready, b_out_valid, b_ovf;
  logic [15:0] b_min, b_max;
  logic [1:0]  b_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  point_bbox_acc #(.CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_point(in_point), .in_last(in_last), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_min(a_min), .out_max(a_max),
    .out_count(a_cnt), .out_ovf(a_ovf)
  );

  point_bbox_acc #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_point(in_point), .in_last(in_last), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_min(b_min), .out_max(b_max),
    .out_count(b_cnt), .out_ovf(b_ovf)
  );

  typedef struct {
    int          n;
    logic [15:0] pts [10];
    logic [15:0] emin;
    logic [15:0] emax;
    int          ecnt_a;
    int          ecnt_b;
    bit          eovf_b;
  } vec_t;

  vec_t tv [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  // Present one point from a negedge; returns at the negedge after it was accepted.
  task automatic push(input logic [15:0] p, input logic last);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_point = p;
    in_last  = last;
    while (!a_in_ready && w < 64) begin
      @(negedge clk);
      w++;
    end
    if (w >= 64) chk("push_timeout", {31'd0, a_in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_point = 'x;
    in_last  = 'x;
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_valid_a"}, {31'd0, a_out_valid}, 32'd0);
    chk({nm, "_valid_b"}, {31'd0, b_out_valid}, 32'd0);
    chk({nm, "_min"}, {16'd0, a_min}, 32'h0000FFFF);
    chk({nm, "_max"}, {16'd0, a_max}, 32'd0);
    chk({nm, "_cnt_a"}, {16'd0, a_cnt}, 32'd0);
    chk({nm, "_cnt_b"}, {30'd0, b_cnt}, 32'd0);
    chk({nm, "_ovf_b"}, {31'd0, b_ovf}, 32'd0);
  endtask

  task automatic check_result(input string nm, input logic [15:0] emin, input logic [15:0] emax,
                              input int ecnt_a, input int ecnt_b, input bit eovf_b);
    chk({nm, "_valid_a"}, {31'd0, a_out_valid}, 32'd1);
    chk({nm, "_valid_b"}, {31'd0, b_out_valid}, 32'd1);
    chk({nm, "_ready"}, {30'd0, a_in_ready, b_in_ready}, 32'd0);
    chk({nm, "_min_a"}, {16'd0, a_min}, {16'd0, emin});
    chk({nm, "_max_a"}, {16'd0, a_max}, {16'd0, emax});
    chk({nm, "_min_b"}, {16'd0, b_min}, {16'd0, emin});
    chk({nm, "_max_b"}, {16'd0, b_max}, {16'd0, emax});
    chk({nm, "_cnt_a"}, {16'd0, a_cnt}, ecnt_a);
    chk({nm, "_ovf_a"}, {31'd0, a_ovf}, 32'd0);
    chk({nm, "_cnt_b"}, {30'd0, b_cnt}, ecnt_b);
    chk({nm, "_ovf_b"}, {31'd0, b_ovf}, {31'd0, eovf_b});
  endtask

  // Reference: box corners from per-component extremes of the whole frame.
  task automatic model(input logic [15:0] q[$], output logic [15:0] mn, output logic [15:0] mx);
    int minx, miny, maxx, maxy;
    minx = 255; miny = 255; maxx = 0; maxy = 0;
    foreach (q[i]) begin
      if (int'(q[i][15:8]) < minx) minx = int'(q[i][15:8]);
      if (int'(q[i][7:0])  < miny) miny = int'(q[i][7:0]);
      if (int'(q[i][15:8]) > maxx) maxx = int'(q[i][15:8]);
      if (int'(q[i][7:0])  > maxy) maxy = int'(q[i][7:0]);
    end
    mn = {8'(minx), 8'(miny)};
    mx = {8'(maxx), 8'(maxy)};
  endtask

  initial begin
    logic [15:0] q[$];
    logic [15:0] emin, emax, p;
    int n, k;

    tv[0].n = 3;  tv[0].pts[0] = 16'h0A14; tv[0].pts[1] = 16'h051E; tv[0].pts[2] = 16'h0F01;
    tv[0].emin = 16'h0501; tv[0].emax = 16'h0F1E; tv[0].ecnt_a = 3; tv[0].ecnt_b = 3; tv[0].eovf_b = 0;
    tv[1].n = 1;  tv[1].pts[0] = 16'hFF00;
    tv[1].emin = 16'hFF00; tv[1].emax = 16'hFF00; tv[1].ecnt_a = 1; tv[1].ecnt_b = 1; tv[1].eovf_b = 0;
    tv[2].n = 10;
    for (int i = 0; i < 10; i++) tv[2].pts[i] = {8'(i % 8), 8'(i % 8)};
    tv[2].emin = 16'h0000; tv[2].emax = 16'h0707; tv[2].ecnt_a = 10; tv[2].ecnt_b = 3; tv[2].eovf_b = 1;
    tv[3].n = 5;  tv[3].pts[0] = 16'h0102; tv[3].pts[1] = 16'h0304; tv[3].pts[2] = 16'h0506;
    tv[3].pts[3] = 16'h0708; tv[3].pts[4] = 16'h090A;
    tv[3].emin = 16'h0102; tv[3].emax = 16'h090A; tv[3].ecnt_a = 5; tv[3].ecnt_b = 3; tv[3].eovf_b = 1;
    tv[4].n = 2;  tv[4].pts[0] = 16'h8001; tv[4].pts[1] = 16'h0180;
    tv[4].emin = 16'h0101; tv[4].emax = 16'h8080; tv[4].ecnt_a = 2; tv[4].ecnt_b = 2; tv[4].eovf_b = 0;
    tv[5].n = 3;  tv[5].pts[0] = 16'h5A5A; tv[5].pts[1] = 16'h5A5A; tv[5].pts[2] = 16'h5A5A;
    tv[5].emin = 16'h5A5A; tv[5].emax = 16'h5A5A; tv[5].ecnt_a = 3; tv[5].ecnt_b = 3; tv[5].eovf_b = 0;

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_point = 16'h0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    chk("reset_ready", {30'd0, a_in_ready, b_in_ready}, 32'd3);
    rst = 1'b0;
    @(negedge clk);

    // Table vectors with the sink always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < tv[i].n; j++) push(tv[i].pts[j], j == tv[i].n - 1);
      check_result($sformatf("vec%0d", i), tv[i].emin, tv[i].emax, tv[i].ecnt_a, tv[i].ecnt_b, tv[i].eovf_b);
      @(negedge clk);
      chk($sformatf("vec%0d_pulse", i), {31'd0, a_out_valid}, 32'd0);
      chk($sformatf("vec%0d_ready_back", i), {31'd0, a_in_ready}, 32'd1);
      chk($sformatf("vec%0d_min_kept", i), {16'd0, a_min}, {16'd0, tv[i].emin});
    end

    // Output stall with a new point waiting upstream.
    out_ready = 1'b0;
    push(16'h1020, 1'b1);
    check_result("stall_res", 16'h1020, 16'h1020, 1, 1, 1'b0);
    in_valid = 1'b1; in_point = 16'h0101; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_ready", c), {31'd0, a_in_ready}, 32'd0);
      chk($sformatf("stall%0d_valid", c), {31'd0, a_out_valid}, 32'd1);
      chk($sformatf("stall%0d_box", c), {a_min, a_max}, 32'h10201020);
      chk($sformatf("stall%0d_cnt", c), {16'd0, a_cnt}, 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_deliver_valid", {31'd0, a_out_valid}, 32'd0);
    chk("stall_deliver_ready", {31'd0, a_in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0; in_point = 'x; in_last = 'x;
    check_result("stall_fresh", 16'h0101, 16'h0101, 1, 1, 1'b0);
    @(negedge clk);

    // Reset in the middle of an open frame.
    push(16'h1111, 1'b0);
    push(16'h2222, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_vals("rst_acc");
    @(negedge clk);
    rst = 1'b0;
    push(16'h4040, 1'b0);
    push(16'h413F, 1'b1);
    check_result("after_rst", 16'h403F, 16'h4140, 2, 2, 1'b0);
    @(negedge clk);

    // Reset while a result is pending.
    out_ready = 1'b0;
    push(16'h7777, 1'b1);
    chk("hold_valid", {31'd0, a_out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_vals("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_hold_ready", {31'd0, a_in_ready}, 32'd1);

    // Random frames with idle gaps and sink stalls.
    for (int f = 0; f < 40; f++) begin
      q.delete();
      n = $urandom_range(1, 7);
      out_ready = 1'b0;
      for (int j = 0; j < n; j++) begin
        p = 16'($urandom);
        q.push_back(p);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        push(p, j == n - 1);
      end
      model(q, emin, emax);
      check_result($sformatf("rnd%0d", f), emin, emax, n, (n > 3) ? 3 : n, n > 3);
      k = $urandom_range(0, 3);
      for (int c = 0; c < k; c++) begin
        @(negedge clk);
        chk($sformatf("rnd%0d_hold", f), {a_out_valid, 15'd0, a_min}, {1'b1, 15'd0, emin});
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("rnd%0d_done", f), {30'd0, a_out_valid, a_in_ready}, 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
